// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_WIDTH_DEF = 8;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO-write bundle between producers, arbiter and FIFO.
// Latency: n/a (wires only).
// Backpressure: req_ready_o / fifo_full_i carried as plain signals.
// Optional err_cnt_o exists only when FIFO_WR_ARB_ERR_CNT_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_last_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ-1:0]       grant_o;
    logic                     busy_o;
    logic                     fifo_full_i;
    logic                     fifo_wr_error_i;
    logic                     fifo_wr_en_o;
    logic [WIDTH-1:0]         fifo_wdata_o;
`ifdef FIFO_WR_ARB_ERR_CNT_EN
    logic [NUM_REQ*CNT_WIDTH-1:0] err_cnt_o;
`endif

    // Arbiter side.
    modport master (
        input  req_valid_i, req_data_i, req_last_i, fifo_full_i, fifo_wr_error_i,
        output req_ready_o, grant_o, busy_o, fifo_wr_en_o, fifo_wdata_o
`ifdef FIFO_WR_ARB_ERR_CNT_EN
        , output err_cnt_o
`endif
    );

    // Producer / FIFO side.
    modport slave (
        output req_valid_i, req_data_i, req_last_i, fifo_full_i, fifo_wr_error_i,
        input  req_ready_o, grant_o, busy_o, fifo_wr_en_o, fifo_wdata_o
`ifdef FIFO_WR_ARB_ERR_CNT_EN
        , input err_cnt_o
`endif
    );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin selector: first valid requester after last_owner, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of valid and last_owner.
module rr_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic found;
    int   cand;

    // Scan NUM_REQ positions starting just after last_owner; first hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_owner) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && valid[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers (macro: FIFO_WR_ARB_ERR_CNT_EN adds error counters).
// Latency: 1 cycle valid-to-grant; beats pass combinationally to the FIFO, one IDLE bubble per release.
// Backpressure: owner ready = !fifo_full_i, all others 0; no write ever issued while full.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fifo_wr_arbiter_if.master bus
);

    localparam int IDX_W = req_idx_w(NUM_REQ);
    localparam int BC_W  = req_idx_w(MAX_BURST);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_BURST = BURST;

    logic [0:0]         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic [BC_W-1:0]    beat_cnt;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_pick;

    logic               in_burst;
    logic               owner_vld;
    logic               owner_last;
    logic [WIDTH-1:0]   owner_data;
    logic               beat;
    logic               burst_end;
    logic               release_burst;

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid      (bus.req_valid_i),
        .last_owner (last_owner),
        .pick       (pick),
        .pick_idx   (pick_idx)
    );

    assign any_pick = |pick;

    // Outputs are forced quiet while reset is asserted, even mid-burst.
    assign in_burst   = (state == S_BURST) && !rst_i;
    assign owner_vld  = bus.req_valid_i[owner];
    assign owner_last = bus.req_last_i[owner];
    assign owner_data = bus.req_data_i[owner*WIDTH +: WIDTH];

    assign beat          = in_burst && owner_vld && !bus.fifo_full_i;
    assign burst_end     = (beat_cnt == BC_W'(MAX_BURST - 1));
    assign release_burst = in_burst && (!owner_vld || (beat && (owner_last || burst_end)));

    // Grant/ready fan-out and the zero-buffer write path to the FIFO.
    always_comb begin
        bus.grant_o      = '0;
        bus.req_ready_o  = '0;
        if (in_burst) begin
            bus.grant_o[owner]     = 1'b1;
            bus.req_ready_o[owner] = !bus.fifo_full_i;
        end
        bus.busy_o       = in_burst;
        bus.fifo_wr_en_o = beat;
        bus.fifo_wdata_o = beat ? owner_data : '0;
    end

    // IDLE/BURST sequencing with round-robin pointer and burst beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (any_pick) begin
                state    <= S_BURST;
                owner    <= pick_idx;
                beat_cnt <= '0;
            end
        end else begin
            if (release_burst) begin
                state      <= S_IDLE;
                last_owner <= owner;
                beat_cnt   <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_WR_ARB_ERR_CNT_EN
    logic [IDX_W-1:0]     last_wr_idx;
    logic                 last_wr_vld;
    logic [CNT_WIDTH-1:0] err_cnt [NUM_REQ];

    // The FIFO flags a rejected write one cycle late, so blame the previous beat's owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_wr_idx <= '0;
            last_wr_vld <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                err_cnt[k] <= '0;
            end
        end else begin
            last_wr_idx <= owner;
            last_wr_vld <= beat;
            if (bus.fifo_wr_error_i && last_wr_vld && (err_cnt[last_wr_idx] != '1)) begin
                err_cnt[last_wr_idx] <= err_cnt[last_wr_idx] + 1'b1;
            end
        end
    end

    // Flatten counters onto the output bus; zero while reset is held.
    always_comb begin
        bus.err_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = rst_i ? '0 : err_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle expected outputs queued per scenario.
// Latency: checks sampled at negedge, inputs changed 1 unit after posedge.
// Backpressure: fifo_full_i and producer withdrawal driven from scenario code.
module tb_fifo_wr_arbiter;
    import fifo_wr_arb_pkg::*;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CNT_WIDTH(CW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .MAX_BURST (MB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [NR-1:0] grant;
        logic [NR-1:0] ready;
        logic [W-1:0]  data;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    // Stimulus state applied at the start of each tick.
    logic [NR-1:0] vmask;
    logic          full;
    logic          err_in;
    logic          rst_r;
    logic          sb_en;
    int            seq     [NR];
    int            lastper [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int k, input int s);
        return {4'(k), 4'(s)};
    endfunction

    task automatic push_idle();
        exp_t e;
        e.wr = 1'b0; e.grant = '0; e.ready = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_beat(input int k, input int s);
        exp_t e;
        e.wr = 1'b1; e.grant = NR'(1 << k); e.ready = NR'(1 << k); e.data = word_of(k, s);
        exp_q.push_back(e);
    endtask

    task automatic push_stall(input int k);
        exp_t e;
        e.wr = 1'b0; e.grant = NR'(1 << k); e.ready = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic apply_inputs();
        rst = rst_r;
        bus.req_valid_i     = vmask;
        bus.fifo_full_i     = full;
        bus.fifo_wr_error_i = err_in;
        for (int k = 0; k < NR; k++) begin
            bus.req_data_i[k*W +: W] = word_of(k, seq[k]);
            bus.req_last_i[k] = (lastper[k] != 0) && (((seq[k] + 1) % lastper[k]) == 0);
        end
    endtask

    task automatic tick();
        exp_t          e;
        logic [NR-1:0] acc;
        apply_inputs();
        @(negedge clk);
        if (sb_en) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_en", 32'(bus.fifo_wr_en_o), 32'(e.wr));
                chk("grant", 32'(bus.grant_o), 32'(e.grant));
                chk("ready", 32'(bus.req_ready_o), 32'(e.ready));
                chk("wdata", 32'(bus.fifo_wdata_o), 32'(e.data));
                chk("busy", 32'(bus.busy_o), 32'(|e.grant));
            end
        end
        acc = bus.req_valid_i & bus.req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) seq[k]++;
        end
    endtask

    task automatic new_scenario();
        vmask = '0; full = 1'b0; err_in = 1'b0; rst_r = 1'b0;
        for (int k = 0; k < NR; k++) begin
            seq[k] = 0;
            lastper[k] = 0;
        end
    endtask

    task automatic do_reset(input int n);
        rst_r = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (sb_en) push_idle();
            tick();
        end
        rst_r = 1'b0;
    endtask

    task automatic end_scenario(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_en = 1'b1;

        // Reset with all valid, then full round robin 0,1,2,3,0.
        new_scenario();
        vmask = 4'hF;
        do_reset(2);
        push_idle();
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < MB; b++) push_beat(r, b);
            push_idle();
        end
        for (int b = 0; b < MB; b++) push_beat(0, MB + b);
        push_idle();
        repeat (26) tick();
        end_scenario("rr_left");

        // Only requester 2, packets of two words.
        new_scenario();
        vmask = 4'b0100;
        lastper[2] = 2;
        do_reset(2);
        push_idle();
        push_beat(2, 0); push_beat(2, 1);
        push_idle();
        push_beat(2, 2); push_beat(2, 3);
        push_idle();
        repeat (7) tick();
        end_scenario("last_left");

        // Requester 1 stalled by FIFO full for three cycles after its first beat.
        new_scenario();
        vmask = 4'b0010;
        do_reset(2);
        push_idle();
        push_beat(1, 0);
        push_stall(1); push_stall(1); push_stall(1);
        push_beat(1, 1); push_beat(1, 2); push_beat(1, 3);
        push_idle();
        push_beat(1, 4);
        tick(); tick();
        full = 1'b1;
        repeat (3) tick();
        full = 1'b0;
        repeat (5) tick();
        end_scenario("full_left");

        // Requester 0 withdraws while FIFO is full; requester 2 takes over.
        new_scenario();
        vmask = 4'b0101;
        do_reset(2);
        push_idle();
        push_beat(0, 0); push_beat(0, 1);
        push_stall(0);
        push_idle();
        for (int b = 0; b < MB; b++) push_beat(2, b);
        push_idle();
        push_beat(2, 4);
        repeat (3) tick();
        vmask = 4'b0100;
        full  = 1'b1;
        tick();
        full  = 1'b0;
        repeat (7) tick();
        end_scenario("wd_left");

        // Reset mid-burst of requester 1, then re-arbitrate with all valid.
        new_scenario();
        vmask = 4'b0010;
        do_reset(2);
        push_idle();
        push_beat(1, 0); push_beat(1, 1);
        push_idle();
        push_idle();
        push_beat(0, 0);
        repeat (3) tick();
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        vmask = 4'hF;
        tick(); tick();
        end_scenario("mid_rst_left");

`ifdef FIFO_WR_ARB_ERR_CNT_EN
        // Error attribution to the previous beat's owner, then saturation.
        sb_en = 1'b0;
        new_scenario();
        vmask = 4'b1000;
        lastper[3] = 1;
        do_reset(2);
        tick();
        for (int k = 0; k < NR; k++) chk("err_rst", 32'(bus.err_cnt_o[k*CW +: CW]), 32'd0);
        tick();
        err_in = 1'b1;
        tick();
        tick();
        err_in = 1'b0;
        for (int k = 0; k < NR; k++) begin
            chk("err_one", 32'(bus.err_cnt_o[k*CW +: CW]), (k == 3) ? 32'd1 : 32'd0);
        end
        lastper[3] = 0;
        err_in = 1'b1;
        repeat (400) tick();
        err_in = 1'b0;
        tick();
        for (int k = 0; k < NR; k++) begin
            chk("err_sat", 32'(bus.err_cnt_o[k*CW +: CW]), (k == 3) ? 32'd255 : 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
